rv32i_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the RV32i pipeline's instruction fetch port and data access port. It accepts at most one outstanding transaction, gives data accesses priority with a bounded-starvation guarantee for fetch, and returns registered responses. It sits between the RV32i top level (imem_*/dmem_* ports) and the memory/bus model. The core stalls on imem_valid_o and dmem_ready_o.

---
 rtl/rv32i_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access.
// Define RV32I_ARB_PERF_EN to add fetch/data grant and conflict counters.
module rv32i_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_add_i,
  output logic [DATA_W-1:0]   imem_data_o,
  output logic                imem_valid_o,
  input  logic                dmem_re_i,
  input  logic                dmem_we_i,
  input  logic [ADDR_W-1:0]   dmem_add_i,
  input  logic [DATA_W-1:0]   dmem_di_i,
  input  logic [DATA_W/8-1:0] dmem_ble_i,
  output logic [DATA_W-1:0]   dmem_do_o,
  output logic                dmem_ready_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_add_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_ble_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef RV32I_ARB_PERF_EN
  ,
  output logic [31:0]         perf_igrant_o,
  output logic [31:0]         perf_dgrant_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam int unsigned BLE_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BLE_W-1:0]  ble_q, ble_d;
  logic [DATA_W-1:0] imem_data_q, imem_data_d;
  logic [DATA_W-1:0] dmem_do_q, dmem_do_d;
  logic              imem_valid_q, imem_valid_d;
  logic              dmem_ready_q, dmem_ready_d;

  logic dreq;
  logic fetch_win;
  logic igrant;
  logic dgrant;

  // A read+write request is treated as a write, so any data request counts here.
  assign dreq      = dmem_re_i | dmem_we_i;
  assign fetch_win = imem_req_i & (~dreq | (starve_cnt_q == STARVE_LIM));
  assign igrant    = (state_q == ST_IDLE) & fetch_win;
  assign dgrant    = (state_q == ST_IDLE) & dreq & ~fetch_win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ble_d        = ble_q;
    imem_data_d  = imem_data_q;
    dmem_do_d    = dmem_do_q;
    imem_valid_d = 1'b0;
    dmem_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!imem_req_i || igrant) begin
          starve_cnt_d = '0;
        end else if (dgrant && (starve_cnt_q != STARVE_LIM)) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if (igrant) begin
          owner_d = OWN_I;
          addr_d  = imem_add_i;
          we_d    = 1'b0;
          wdata_d = '0;
          ble_d   = '1;
          state_d = ST_REQ;
        end else if (dgrant) begin
          owner_d = OWN_D;
          addr_d  = dmem_add_i;
          we_d    = dmem_we_i;
          wdata_d = dmem_di_i;
          ble_d   = dmem_ble_i;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            dmem_ready_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWN_I) begin
            imem_data_d  = mem_rdata_i;
            imem_valid_d = 1'b1;
          end else begin
            dmem_do_d    = mem_rdata_i;
            dmem_ready_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      ble_q        <= '0;
      imem_data_q  <= '0;
      dmem_do_q    <= '0;
      imem_valid_q <= 1'b0;
      dmem_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ble_q        <= ble_d;
      imem_data_q  <= imem_data_d;
      dmem_do_q    <= dmem_do_d;
      imem_valid_q <= imem_valid_d;
      dmem_ready_q <= dmem_ready_d;
    end
  end

  assign mem_req_o    = (state_q == ST_REQ);
  assign mem_we_o     = mem_req_o & we_q;
  assign mem_add_o    = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_ble_o    = ble_q;
  assign imem_data_o  = imem_data_q;
  assign imem_valid_o = imem_valid_q;
  assign dmem_do_o    = dmem_do_q;
  assign dmem_ready_o = dmem_ready_q;

`ifdef RV32I_ARB_PERF_EN
  logic [31:0] perf_igrant_q, perf_igrant_d;
  logic [31:0] perf_dgrant_q, perf_dgrant_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_igrant_d   = perf_igrant_q + {31'd0, igrant};
    perf_dgrant_d   = perf_dgrant_q + {31'd0, dgrant};
    perf_conflict_d = perf_conflict_q + {31'd0, (state_q == ST_IDLE) & imem_req_i & dreq};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_igrant_q   <= '0;
      perf_dgrant_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_igrant_q   <= perf_igrant_d;
      perf_dgrant_q   <= perf_dgrant_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_igrant_o   = perf_igrant_q;
  assign perf_dgrant_o   = perf_dgrant_q;
  assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model of the arbitration and response rules.
module tb_rv32i_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          imem_req_i;
  logic [AW-1:0] imem_add_i;
  logic [DW-1:0] imem_data_o;
  logic          imem_valid_o;
  logic          dmem_re_i;
  logic          dmem_we_i;
  logic [AW-1:0] dmem_add_i;
  logic [DW-1:0] dmem_di_i;
  logic [3:0]    dmem_ble_i;
  logic [DW-1:0] dmem_do_o;
  logic          dmem_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_add_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_ble_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
`ifdef RV32I_ARB_PERF_EN
  logic [31:0]   perf_igrant_o;
  logic [31:0]   perf_dgrant_o;
  logic [31:0]   perf_conflict_o;
`endif

  rv32i_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SM)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .imem_req_i  (imem_req_i),
    .imem_add_i  (imem_add_i),
    .imem_data_o (imem_data_o),
    .imem_valid_o(imem_valid_o),
    .dmem_re_i   (dmem_re_i),
    .dmem_we_i   (dmem_we_i),
    .dmem_add_i  (dmem_add_i),
    .dmem_di_i   (dmem_di_i),
    .dmem_ble_i  (dmem_ble_i),
    .dmem_do_o   (dmem_do_o),
    .dmem_ready_o(dmem_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_add_o   (mem_add_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ble_o   (mem_ble_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef RV32I_ARB_PERF_EN
    ,
    .perf_igrant_o  (perf_igrant_o),
    .perf_dgrant_o  (perf_dgrant_o),
    .perf_conflict_o(perf_conflict_o)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending transaction, whether memory has accepted it,
  // and the count of consecutive data wins over a waiting fetch.
  bit          m_busy, m_granted, m_ivalid, m_dready;
  bit          t_fetch, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_ble;
  int unsigned m_starve;
  logic [31:0] m_idata, m_ddo;
  logic [31:0] p_ig, p_dg, p_cf;

  task automatic model_step();
    bit dreq;
    bit fw;
    m_ivalid = 1'b0;
    m_dready = 1'b0;
    if (reset_i) begin
      m_busy = 0; m_granted = 0; m_starve = 0;
      m_idata = '0; m_ddo = '0;
      p_ig = '0; p_dg = '0; p_cf = '0;
      return;
    end
    dreq = dmem_re_i | dmem_we_i;
    if (!m_busy) begin
      if (imem_req_i && dreq) p_cf++;
      fw = imem_req_i && (!dreq || m_starve == SM);
      if (fw) begin
        t_fetch = 1; t_addr = imem_add_i; t_we = 0; t_ble = 4'hF; t_wdata = '0;
        m_busy = 1; m_granted = 0; m_starve = 0; p_ig++;
      end else if (dreq) begin
        t_fetch = 0; t_addr = dmem_add_i; t_we = dmem_we_i; t_ble = dmem_ble_i; t_wdata = dmem_di_i;
        m_busy = 1; m_granted = 0; p_dg++;
        if (imem_req_i && m_starve < SM) m_starve++;
      end
      if (!imem_req_i) m_starve = 0;
    end else if (!m_granted) begin
      if (mem_gnt_i) begin
        if (t_we) begin
          m_dready = 1; m_busy = 0;
        end else begin
          m_granted = 1;
        end
      end
    end else if (mem_rvalid_i) begin
      if (t_fetch) begin
        m_idata = mem_rdata_i; m_ivalid = 1;
      end else begin
        m_ddo = mem_rdata_i; m_dready = 1;
      end
      m_busy = 0; m_granted = 0;
    end
  endtask

  task automatic compare_all();
    check("mem_req", 32'(mem_req_o), 32'(m_busy && !m_granted));
    if (m_busy && !m_granted) begin
      check("mem_add", mem_add_o, t_addr);
      check("mem_we", 32'(mem_we_o), 32'(t_we));
      check("mem_ble", 32'(mem_ble_o), 32'(t_ble));
      if (t_we) check("mem_wdata", mem_wdata_o, t_wdata);
    end
    check("imem_valid", 32'(imem_valid_o), 32'(m_ivalid));
    check("dmem_ready", 32'(dmem_ready_o), 32'(m_dready));
    check("imem_data", imem_data_o, m_idata);
    check("dmem_do", dmem_do_o, m_ddo);
`ifdef RV32I_ARB_PERF_EN
    check("perf_igrant", perf_igrant_o, p_ig);
    check("perf_dgrant", perf_dgrant_o, p_dg);
    check("perf_conflict", perf_conflict_o, p_cf);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive_random();
    if (reset_i) reset_i = 1'b0;
    else if ($urandom_range(0, 299) == 0) reset_i = 1'b1;
    if ($urandom_range(0, 3) == 0) imem_req_i = ~imem_req_i;
    if ($urandom_range(0, 3) == 0) {dmem_re_i, dmem_we_i} = 2'($urandom_range(0, 3));
    imem_add_i   = $urandom & 32'hFFFF_FFFC;
    dmem_add_i   = $urandom;
    dmem_di_i    = $urandom;
    dmem_ble_i   = 4'($urandom_range(0, 15));
    mem_gnt_i    = ($urandom_range(0, 2) != 0);
    mem_rvalid_i = ($urandom_range(0, 1) != 0);
    mem_rdata_i  = $urandom;
  endtask

  initial begin
    int lat;
    int pulses;
    int ntx;
    bit is_f;

    reset_i = 1'b1;
    imem_req_i = 0; imem_add_i = '0;
    dmem_re_i = 0; dmem_we_i = 0; dmem_add_i = '0; dmem_di_i = '0; dmem_ble_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    cycle();
    cycle();
    check("rst_mem_add", mem_add_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_mem_ble", 32'(mem_ble_o), 32'h0);
    check("rst_mem_we", 32'(mem_we_o), 32'h0);
    reset_i = 1'b0;
    cycle();

    // Fetch only, zero-wait memory
    imem_req_i = 1; imem_add_i = 32'h100;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 1) begin
        check("fetch_req", 32'(mem_req_o), 32'h1);
        check("fetch_add", mem_add_o, 32'h100);
        check("fetch_ble", 32'(mem_ble_o), 32'hF);
      end
      if (imem_valid_o) begin
        lat = c; imem_req_i = 0; break;
      end
    end
    check("fetch_latency", 32'(lat), 32'd3);
    check("fetch_data", imem_data_o, 32'h0050_0093);

    // Write
    dmem_we_i = 1; dmem_add_i = 32'h2000; dmem_di_i = 32'hDEAD_BEEF; dmem_ble_i = 4'h3;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (c == 1) begin
        check("wr_we", 32'(mem_we_o), 32'h1);
        check("wr_add", mem_add_o, 32'h2000);
        check("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("wr_ble", 32'(mem_ble_o), 32'h3);
      end
      if (dmem_ready_o) begin
        lat = c; dmem_we_i = 0; break;
      end
    end
    check("write_latency", 32'(lat), 32'd2);

    // Back-pressure; requester also drops its request after the latch
    dmem_we_i = 1; dmem_add_i = 32'h44; dmem_di_i = 32'h1234_5678; dmem_ble_i = 4'hF;
    mem_gnt_i = 0;
    cycle();
    dmem_we_i = 0; dmem_add_i = $urandom; dmem_di_i = $urandom;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      check("bp_req", 32'(mem_req_o), 32'h1);
      check("bp_add", mem_add_o, 32'h44);
      check("bp_wdata", mem_wdata_o, 32'h1234_5678);
      cycle();
      pulses += int'(dmem_ready_o);
    end
    mem_gnt_i = 1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      pulses += int'(dmem_ready_o);
    end
    check("bp_pulses", 32'(pulses), 32'd1);

    // Conflict: data first, then fetch
    imem_req_i = 1; imem_add_i = 32'h200; dmem_re_i = 1; dmem_add_i = 32'h3000;
    mem_gnt_i = 1; mem_rvalid_i = 1;
    ntx = 0;
    for (int c = 0; c < 30 && ntx < 2; c++) begin
      cycle();
      if (mem_req_o) begin
        check(ntx == 0 ? "conflict_first" : "conflict_second", mem_add_o,
              ntx == 0 ? 32'h3000 : 32'h200);
        ntx++;
      end
      if (imem_valid_o) imem_req_i = 0;
      if (dmem_ready_o) dmem_re_i = 0;
    end
    check("conflict_count", 32'(ntx), 32'd2);
    imem_req_i = 0; dmem_re_i = 0;
    for (int c = 0; c < 4; c++) cycle();

    // Starvation: both held continuously
    imem_req_i = 1; imem_add_i = 32'h100; dmem_re_i = 1; dmem_add_i = 32'h3000;
    ntx = 0;
    for (int c = 0; c < 60 && ntx < 6; c++) begin
      cycle();
      if (mem_req_o) begin
        is_f = (mem_add_o == 32'h100);
        check("starve_owner", 32'(is_f), 32'(ntx == 4));
        ntx++;
      end
    end
    check("starve_count", 32'(ntx), 32'd6);
    imem_req_i = 0; dmem_re_i = 0;
    for (int c = 0; c < 4; c++) cycle();

    // Reset while waiting for read data
    imem_req_i = 1; imem_add_i = 32'h180; mem_gnt_i = 1; mem_rvalid_i = 0;
    cycle();
    imem_req_i = 0;
    cycle();
    mem_gnt_i = 0;
    reset_i = 1;
    #1;
    check("rstw_req", 32'(mem_req_o), 32'h0);
    check("rstw_idata", imem_data_o, 32'h0);
    check("rstw_ddo", dmem_do_o, 32'h0);
    check("rstw_add", mem_add_o, 32'h0);
    check("rstw_ivalid", 32'(imem_valid_o), 32'h0);
    cycle();
    reset_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("late_rvalid_ivalid", 32'(imem_valid_o), 32'h0);
      check("late_rvalid_dready", 32'(dmem_ready_o), 32'h0);
      check("late_rvalid_req", 32'(mem_req_o), 32'h0);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
